pong_game_ctrl: RTL and testbench

//  Game sequencer for the ping-pong display. Owns ball position/velocity, both

---
 rtl/pong_game_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Ping-pong game sequencer. Owns the ball, both paddles and both scores,
// advances them once per video frame, and sequences the serve / play /
// point / game-over phases for the VGA draw logic and score display.
//
// Inputs are sampled on the rising edge of pixel_clk. frame_tick and start
// are single-cycle pulses. Every output comes straight from a register, so
// it changes only on the clock edge after a qualifying pulse.
module pong_game_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 25,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 150,
    parameter int PADDLE_L_X   = 40,
    parameter int PADDLE_R_X   = 600,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 6,
    parameter int SERVE_DELAY  = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pad_l_up,
    input  logic       pad_l_dn,
    input  logic       pad_r_up,
    input  logic       pad_r_dn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] game_state,
    output logic       game_over
);

    // Geometry in the signed 12-bit domain used for all position math.
    localparam logic signed [11:0] CX     = 12'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [11:0] CY     = 12'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [11:0] PY     = 12'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic signed [11:0] Y_MAX  = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] X_MAX  = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] P_MAX  = 12'(V_ACTIVE - PADDLE_H);
    localparam logic signed [11:0] L_FACE = 12'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [11:0] R_FACE = 12'(PADDLE_R_X);
    localparam logic signed [11:0] R_STOP = 12'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [11:0] B_SZ   = 12'(BALL_SIZE);
    localparam logic signed [11:0] P_H    = 12'(PADDLE_H);
    localparam logic signed [11:0] B_SPD  = 12'(BALL_SPEED);
    localparam logic signed [11:0] P_SPD  = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] ZERO   = 12'sd0;
    localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

    // Serve counter only needs to reach SERVE_DELAY-1 before wrapping to 0.
    localparam int              CW       = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SERVE_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               state;
    logic signed [11:0]   bx;
    logic signed [11:0]   by;
    logic signed [11:0]   pl;
    logic signed [11:0]   pr;
    logic                 vx_pos;       // 1: ball moving right
    logic                 vy_pos;       // 1: ball moving down
    logic                 left_scored;  // who takes the point in POINT
    logic [CW-1:0]        cnt;

    logic signed [11:0]   vx;
    logic signed [11:0]   vy;
    logic signed [11:0]   nx;
    logic signed [11:0]   ny;
    logic signed [11:0]   y_next;
    logic                 vy_pos_next;
    logic                 hit_l;
    logic                 hit_r;
    logic                 miss_l;
    logic                 miss_r;
    logic signed [11:0]   pl_next;
    logic signed [11:0]   pr_next;
    logic [3:0]           score_l_inc;
    logic [3:0]           score_r_inc;

    // One paddle step; opposing buttons cancel, result clamped to the screen.
    function automatic logic signed [11:0] pad_step(input logic signed [11:0] y,
                                                     input logic up,
                                                     input logic dn);
        logic signed [11:0] t;
        t = y;
        if (up && !dn) begin
            t = (y - P_SPD < ZERO) ? ZERO : y - P_SPD;
        end else if (dn && !up) begin
            t = (y + P_SPD > P_MAX) ? P_MAX : y + P_SPD;
        end
        return t;
    endfunction

    // Candidate ball move for a PLAY frame: walls first, then paddles, then misses.
    always_comb begin
        vx          = vx_pos ? B_SPD : -B_SPD;
        vy          = vy_pos ? B_SPD : -B_SPD;
        nx          = bx + vx;
        ny          = by + vy;
        y_next      = ny;
        vy_pos_next = vy_pos;
        if (ny < ZERO) begin
            y_next      = ZERO;
            vy_pos_next = 1'b1;
        end else if (ny > Y_MAX) begin
            y_next      = Y_MAX;
            vy_pos_next = 1'b0;
        end
        // Paddle overlap uses the ball row before this frame's vertical move.
        hit_l  = !vx_pos && (nx <= L_FACE) && (by + B_SZ > pl) && (by < pl + P_H);
        hit_r  = vx_pos && (nx + B_SZ >= R_FACE) && (by + B_SZ > pr) && (by < pr + P_H);
        miss_l = !hit_l && !hit_r && (nx <= ZERO);
        miss_r = !hit_l && !hit_r && (nx >= X_MAX);
        pl_next     = pad_step(pl, pad_l_up, pad_l_dn);
        pr_next     = pad_step(pr, pad_r_up, pad_r_dn);
        score_l_inc = (score_l >= WIN) ? score_l : score_l + 4'd1;
        score_r_inc = (score_r >= WIN) ? score_r : score_r + 4'd1;
    end

    // Game sequencer: phase, ball, paddles, scores and serve counter.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bx          <= CX;
            by          <= CY;
            pl          <= PY;
            pr          <= PY;
            vx_pos      <= 1'b1;
            vy_pos      <= 1'b1;
            left_scored <= 1'b0;
            cnt         <= '0;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            game_over   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        pl <= pl_next;
                        pr <= pr_next;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_PLAY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        pl     <= pl_next;
                        pr     <= pr_next;
                        by     <= y_next;
                        vy_pos <= vy_pos_next;
                        if (hit_l) begin
                            bx     <= L_FACE;
                            vx_pos <= 1'b1;
                        end else if (hit_r) begin
                            bx     <= R_STOP;
                            vx_pos <= 1'b0;
                        end else if (miss_l) begin
                            bx          <= ZERO;
                            left_scored <= 1'b0;
                            state       <= S_POINT;
                        end else if (miss_r) begin
                            bx          <= X_MAX;
                            left_scored <= 1'b1;
                            state       <= S_POINT;
                        end else begin
                            bx <= nx;
                        end
                    end
                end
                S_POINT: begin
                    // Next serve heads toward the player who just lost the point.
                    vx_pos <= left_scored;
                    vy_pos <= 1'b1;
                    if (left_scored) begin
                        score_l <= score_l_inc;
                    end else begin
                        score_r <= score_r_inc;
                    end
                    if ((left_scored ? score_l_inc : score_r_inc) == WIN) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        bx    <= CX;
                        by    <= CY;
                        state <= S_SERVE;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        bx        <= CX;
                        by        <= CY;
                        pl        <= PY;
                        pr        <= PY;
                        vx_pos    <= 1'b1;
                        vy_pos    <= 1'b1;
                        cnt       <= '0;
                        game_over <= 1'b0;
                        state     <= S_SERVE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ball_x     = bx[9:0];
    assign ball_y     = by[9:0];
    assign paddle_l_y = pl[9:0];
    assign paddle_r_y = pr[9:0];
    assign game_state = state;

    // Positions are clamped to the screen, so the top bits are always zero.
    logic unused_bits;
    assign unused_bits = ^{bx[11:10], by[11:10], pl[11:10], pr[11:10]};

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. Scenarios walk real games: a long rally
// with both paddle hits and a top-wall bounce, eight left points to game
// over, a right point with a leftward serve, and an asynchronous reset.
module tb_pong_game_ctrl;

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       pad_l_up;
    logic       pad_l_dn;
    logic       pad_r_up;
    logic       pad_r_dn;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] game_state;
    logic       game_over;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Expected snapshots: {ball_x, ball_y, pad_l, pad_r, score_l, score_r, state, over}
    logic [51:0] exp_q[$];
    string       name_q[$];

    pong_game_ctrl dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pad_l_up   (pad_l_up),
        .pad_l_dn   (pad_l_dn),
        .pad_r_up   (pad_r_up),
        .pad_r_dn   (pad_r_dn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .game_over  (game_over)
    );

    // Clock
    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [51:0] pk(input int bx, input int by, input int pl, input int pr,
                                       input int sl, input int sr, input int st, input int ov);
        return {10'(bx), 10'(by), 10'(pl), 10'(pr), 4'(sl), 4'(sr), 3'(st), 1'(ov)};
    endfunction

    // One clock cycle of stimulus; returns just after the rising edge.
    task automatic cyc(input logic tk, input logic st);
        @(negedge pixel_clk);
        frame_tick = tk;
        start      = st;
        @(posedge pixel_clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
        end
    endtask

    task automatic expect_now(input string nm, input int bx, input int by, input int pl,
                              input int pr, input int sl, input int sr, input int st,
                              input int ov);
        exp_q.push_back(pk(bx, by, pl, pr, sl, sr, st, ov));
        name_q.push_back(nm);
    endtask

    // Scoreboard monitor: compares the outputs on the falling edge.
    logic [51:0] got;
    logic [51:0] want;
    string       cur_name;
    always @(negedge pixel_clk) begin
        if (exp_q.size() != 0) begin
            want     = exp_q.pop_front();
            cur_name = name_q.pop_front();
            got      = {ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r,
                        game_state, game_over};
            chk_cnt  = chk_cnt + 1;
            if (got == want) begin
                pass_cnt = pass_cnt + 1;
            end else begin
                $display("FAIL %s: got ball=(%0d,%0d) pads=(%0d,%0d) score=%0d:%0d state=%0d over=%0d, expected ball=(%0d,%0d) pads=(%0d,%0d) score=%0d:%0d state=%0d over=%0d",
                         cur_name,
                         got[51:42], got[41:32], got[31:22], got[21:12], got[11:8], got[7:4],
                         got[3:1], got[0],
                         want[51:42], want[41:32], want[31:22], want[21:12], want[11:8],
                         want[7:4], want[3:1], want[0]);
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        pad_l_up   = 1'b0;
        pad_l_dn   = 1'b0;
        pad_r_up   = 1'b0;
        pad_r_dn   = 1'b0;

        repeat (3) @(posedge pixel_clk);
        #1;
        expect_now("reset values", 307, 227, 165, 165, 0, 0, 0, 0);
        @(negedge pixel_clk);
        reset = 1'b0;

        // IDLE ignores frame ticks and paddle buttons.
        pad_l_up = 1'b1;
        cyc(1'b1, 1'b0);
        expect_now("idle hold", 307, 227, 165, 165, 0, 0, 0, 0);
        pad_l_up = 1'b0;

        // Game A: serve with left paddle to the top and right paddle to the bottom.
        cyc(1'b0, 1'b1);
        expect_now("start to serve", 307, 227, 165, 165, 0, 0, 1, 0);
        pad_l_up = 1'b1;
        pad_r_dn = 1'b1;
        cyc(1'b1, 1'b0);
        expect_now("serve tick 1", 307, 227, 159, 171, 0, 0, 1, 0);
        ticks(57);
        cyc(1'b1, 1'b0);
        expect_now("serve tick 59 clamped", 307, 227, 0, 330, 0, 0, 1, 0);
        cyc(1'b1, 1'b0);
        expect_now("serve tick 60 to play", 307, 227, 0, 330, 0, 0, 2, 0);
        pad_l_up = 1'b0;
        pad_r_dn = 1'b0;

        cyc(1'b1, 1'b0);
        expect_now("play tick 1", 311, 231, 0, 330, 0, 0, 2, 0);
        cyc(1'b1, 1'b1);
        expect_now("start ignored in play", 315, 235, 0, 330, 0, 0, 2, 0);
        ticks(64);
        cyc(1'b1, 1'b0);
        expect_now("right paddle hit", 575, 419, 0, 330, 0, 0, 2, 0);
        ticks(103);
        cyc(1'b1, 1'b0);
        expect_now("near top wall", 159, 3, 0, 330, 0, 0, 2, 0);
        cyc(1'b1, 1'b0);
        expect_now("top wall clamp", 155, 0, 0, 330, 0, 0, 2, 0);
        cyc(1'b1, 1'b0);
        expect_now("after top bounce", 151, 4, 0, 330, 0, 0, 2, 0);
        ticks(24);
        cyc(1'b1, 1'b0);
        expect_now("before left paddle", 51, 104, 0, 330, 0, 0, 2, 0);
        cyc(1'b1, 1'b0);
        expect_now("left paddle hit", 50, 108, 0, 330, 0, 0, 2, 0);
        cyc(1'b1, 1'b0);
        expect_now("after left hit", 54, 112, 0, 330, 0, 0, 2, 0);
        ticks(140);
        cyc(1'b1, 1'b0);
        expect_now("right miss to point", 615, 235, 0, 330, 0, 0, 3, 0);

        // A frame tick during POINT must not move paddles or count toward the serve.
        pad_r_up = 1'b1;
        cyc(1'b1, 1'b0);
        expect_now("point to serve", 307, 227, 0, 330, 1, 0, 1, 0);
        ticks(58);
        cyc(1'b1, 1'b0);
        expect_now("B1 serve tick 59", 307, 227, 0, 0, 1, 0, 1, 0);
        cyc(1'b1, 1'b0);
        expect_now("B1 serve tick 60", 307, 227, 0, 0, 1, 0, 2, 0);
        pad_r_up = 1'b0;
        ticks(76);
        cyc(1'b1, 1'b0);
        expect_now("B1 point", 615, 379, 0, 0, 1, 0, 3, 0);
        cyc(1'b0, 1'b0);
        expect_now("B1 score", 307, 227, 0, 0, 2, 0, 1, 0);

        // Seven more left points, the last one ending the game at 9.
        for (int r = 2; r <= 8; r++) begin
            ticks(60);
            ticks(76);
            cyc(1'b1, 1'b0);
            expect_now("rally point", 615, 379, 0, 0, r, 0, 3, 0);
            cyc(1'b0, 1'b0);
            if (r < 8) begin
                expect_now("rally score", 307, 227, 0, 0, r + 1, 0, 1, 0);
            end else begin
                expect_now("win to over", 615, 379, 0, 0, 9, 0, 4, 1);
            end
        end

        pad_l_dn = 1'b1;
        pad_r_dn = 1'b1;
        ticks(3);
        expect_now("over freezes", 615, 379, 0, 0, 9, 0, 4, 1);
        pad_l_dn = 1'b0;
        pad_r_dn = 1'b0;
        cyc(1'b0, 1'b1);
        expect_now("restart from over", 307, 227, 165, 165, 0, 0, 1, 0);

        // Game C: left paddle at the bottom so the ball gets past it.
        pad_l_dn = 1'b1;
        pad_r_dn = 1'b1;
        ticks(59);
        cyc(1'b1, 1'b0);
        expect_now("C serve tick 60", 307, 227, 330, 330, 0, 0, 2, 0);
        pad_l_dn = 1'b0;
        pad_r_dn = 1'b0;
        ticks(198);
        cyc(1'b1, 1'b0);
        expect_now("left paddle missed", 47, 108, 330, 330, 0, 0, 2, 0);
        ticks(11);
        cyc(1'b1, 1'b0);
        expect_now("left miss to point", 0, 156, 330, 330, 0, 0, 3, 0);
        cyc(1'b0, 1'b0);
        expect_now("right scores", 307, 227, 330, 330, 0, 1, 1, 0);

        pad_r_up = 1'b1;
        pad_r_dn = 1'b1;
        ticks(29);
        cyc(1'b1, 1'b0);
        expect_now("both right buttons", 307, 227, 330, 330, 0, 1, 1, 0);
        ticks(29);
        cyc(1'b1, 1'b0);
        expect_now("C2 serve tick 60", 307, 227, 330, 330, 0, 1, 2, 0);
        pad_r_up = 1'b0;
        pad_r_dn = 1'b0;
        cyc(1'b1, 1'b0);
        expect_now("serve toward left", 303, 231, 330, 330, 0, 1, 2, 0);

        // Reset between clock edges must take effect without a rising edge.
        @(posedge pixel_clk);
        #2;
        reset = 1'b1;
        expect_now("async reset", 307, 227, 165, 165, 0, 0, 0, 0);
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        reset = 1'b0;
        repeat (3) @(posedge pixel_clk);

        if (exp_q.size() != 0) begin
            chk_cnt = chk_cnt + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
